// File: rtl/banked_sram_if.sv
// banked_sram_if: per-port request and read-response signals of the banked SRAM
interface banked_sram_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/banked_sram.sv
// banked_sram: multi-port SRAM over independent single-port banks with per-bank round-robin arbitration
module banked_sram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 4,
    parameter int INTERLEAVE = 1
) (
    input logic          clk,
    input logic          rst,
    banked_sram_if.slave bus
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int PTR_BITS  = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    logic [BANK_BITS-1:0]  bank   [NUM_PORTS];
    logic [ROW_BITS-1:0]   row    [NUM_PORTS];
    logic [PTR_BITS-1:0]   rr_ptr [NUM_BANKS];
    logic [PTR_BITS-1:0]   win    [NUM_BANKS];
    logic [NUM_BANKS-1:0]  busy;
    logic [NUM_PORTS-1:0]  grant;
    logic [DATA_WIDTH-1:0] mem    [NUM_BANKS][2**ROW_BITS];
    assign bus.req_ready = grant;
    // split each port address into bank select and row, low- or high-order banking
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank[p] = INTERLEAVE != 0 ? bus.req_addr[p*ADDR_WIDTH +: BANK_BITS]
                                      : bus.req_addr[p*ADDR_WIDTH+ROW_BITS +: BANK_BITS];
            row[p]  = INTERLEAVE != 0 ? bus.req_addr[p*ADDR_WIDTH+BANK_BITS +: ROW_BITS]
                                      : bus.req_addr[p*ADDR_WIDTH +: ROW_BITS];
        end
    end
    // per bank, grant the first valid requester at or after the pointer, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        busy  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            win[b] = '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                idx = (int'(rr_ptr[b]) + o) % NUM_PORTS;
                if (!busy[b] && bus.req_valid[idx] && int'(bank[idx]) == b) begin
                    grant[idx] = 1'b1;
                    win[b]     = PTR_BITS'(idx);
                    busy[b]    = 1'b1;
                end
            end
        end
    end
    // bank storage writes; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (grant[p] && bus.req_we[p])
                mem[bank[p]][row[p]] <= bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
    // advance each active bank's pointer past the port it just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++)
                if (busy[b]) rr_ptr[b] <= PTR_BITS'((int'(win[b]) + 1) % NUM_PORTS);
        end
    end
    // registered read responses; data holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= grant & ~bus.req_we;
            for (int p = 0; p < NUM_PORTS; p++)
                if (grant[p] && !bus.req_we[p])
                    bus.rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= mem[bank[p]][row[p]];
        end
    end
endmodule

// File: tb/tb_banked_sram.sv
// tb_banked_sram: directed checks of arbitration, data path and reset for both banking modes
module tb_banked_sram;
    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    banked_sram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia ();
    banked_sram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib ();
    banked_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(4), .NUM_PORTS(NP), .INTERLEAVE(1))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    banked_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(4), .NUM_PORTS(NP), .INTERLEAVE(0))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic set_a(input int p, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ia.req_valid[p] = v;
        ia.req_we[p] = we;
        ia.req_addr[p*AW +: AW] = a;
        ia.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic set_b(input int p, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ib.req_valid[p] = v;
        ib.req_we[p] = we;
        ib.req_addr[p*AW +: AW] = a;
        ib.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic test_reset();
        for (int p = 0; p < NP; p++) set_a(p, 1'b1, 1'b0, 10'd4, 16'h0);
        @(negedge clk);
        checks++;
        if (ia.rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0000", ia.rsp_valid);
        end
        checks++;
        if (ia.rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rsp_rdata got %h want 0", ia.rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ia.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_winner got %b want 0001", ia.req_ready);
        end
        ia.req_valid = '0;
    endtask

    task automatic test_conflict();
        logic [3:0] exp;
        @(negedge clk);
        set_a(3, 1'b1, 1'b1, 10'd4, 16'h4444);
        #1;
        checks++;
        if (ia.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL conflict_seed_write got %b want 1000", ia.req_ready);
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) set_a(p, 1'b1, 1'b0, 10'd4, 16'h0);
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (ia.req_ready !== exp) begin
                errors++;
                $display("FAIL conflict_grant_%0d got %b want %b", k, ia.req_ready, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ia.rsp_valid !== exp || ia.rsp_rdata[(k%4)*DW +: DW] !== 16'h4444) begin
                errors++;
                $display("FAIL conflict_rsp_%0d got %b/%h want %b/4444", k, ia.rsp_valid, ia.rsp_rdata[(k%4)*DW +: DW], exp);
            end
            @(negedge clk);
        end
        ia.req_valid = '0;
    endtask

    task automatic test_wrap();
        set_a(1, 1'b1, 1'b0, 10'd4, 16'h0);
        set_a(2, 1'b1, 1'b0, 10'd4, 16'h0);
        #1;
        checks++;
        if (ia.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_p1 got %b want 0010", ia.req_ready);
        end
        @(negedge clk);
        ia.req_valid[1] = 1'b0;
        #1;
        checks++;
        if (ia.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_p2 got %b want 0100", ia.req_ready);
        end
        @(negedge clk);
        ia.req_valid = '0;
        set_a(0, 1'b1, 1'b0, 10'd4, 16'h0);
        set_a(3, 1'b1, 1'b0, 10'd4, 16'h0);
        #1;
        checks++;
        if (ia.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_p3 got %b want 1000", ia.req_ready);
        end
        @(negedge clk);
        ia.req_valid[3] = 1'b0;
        #1;
        checks++;
        if (ia.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_p0 got %b want 0001", ia.req_ready);
        end
        @(negedge clk);
        ia.req_valid = '0;
    endtask

    task automatic test_parallel();
        for (int p = 0; p < NP; p++) set_a(p, 1'b1, 1'b1, AW'(p), DW'(16'hA000 + p));
        #1;
        checks++;
        if (ia.req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL parallel_write_ready got %b want 1111", ia.req_ready);
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) set_a(p, 1'b1, 1'b0, AW'(p), 16'h0);
        #1;
        checks++;
        if (ia.req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL parallel_read_ready got %b want 1111", ia.req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b1111) begin
            errors++;
            $display("FAIL parallel_rsp_valid got %b want 1111", ia.rsp_valid);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (ia.rsp_rdata[p*DW +: DW] !== DW'(16'hA000 + p)) begin
                errors++;
                $display("FAIL parallel_rdata_%0d got %h want %h", p, ia.rsp_rdata[p*DW +: DW], 16'hA000 + p);
            end
        end
        @(negedge clk);
        ia.req_valid = '0;
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b0000 || ia.rsp_rdata[0 +: DW] !== 16'hA000) begin
            errors++;
            $display("FAIL parallel_pulse_hold got %b/%h want 0000/a000", ia.rsp_valid, ia.rsp_rdata[0 +: DW]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_a(2, 1'b1, 1'b1, 10'd9, 16'h1234);
        @(negedge clk);
        set_a(2, 1'b1, 1'b0, 10'd9, 16'h0);
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b0100 || ia.rsp_rdata[2*DW +: DW] !== 16'h1234) begin
            errors++;
            $display("FAIL raw_read got %b/%h want 0100/1234", ia.rsp_valid, ia.rsp_rdata[2*DW +: DW]);
        end
        @(negedge clk);
        set_a(2, 1'b1, 1'b0, 10'd1, 16'h0);
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b0100 || ia.rsp_rdata[2*DW +: DW] !== 16'hA001) begin
            errors++;
            $display("FAIL b2b_read got %b/%h want 0100/a001", ia.rsp_valid, ia.rsp_rdata[2*DW +: DW]);
        end
        @(negedge clk);
        ia.req_valid = '0;
    endtask

    task automatic test_interleave0();
        set_b(0, 1'b1, 1'b1, 10'h100, 16'h55AA);
        set_b(1, 1'b1, 1'b1, 10'h001, 16'h0BEE);
        #1;
        checks++;
        if (ib.req_ready !== 4'b0011) begin
            errors++;
            $display("FAIL hi_write_ready got %b want 0011", ib.req_ready);
        end
        @(negedge clk);
        set_b(0, 1'b1, 1'b0, 10'h100, 16'h0);
        set_b(1, 1'b1, 1'b0, 10'h001, 16'h0);
        @(posedge clk);
        #1;
        checks++;
        if (ib.rsp_valid !== 4'b0011 || ib.rsp_rdata[0 +: DW] !== 16'h55AA || ib.rsp_rdata[DW +: DW] !== 16'h0BEE) begin
            errors++;
            $display("FAIL hi_readback got %b/%h/%h want 0011/55aa/0bee", ib.rsp_valid, ib.rsp_rdata[0 +: DW], ib.rsp_rdata[DW +: DW]);
        end
        @(negedge clk);
        set_b(0, 1'b1, 1'b0, 10'h000, 16'h0);
        set_b(1, 1'b1, 1'b0, 10'h001, 16'h0);
        #1;
        checks++;
        if (ib.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL hi_same_bank got %b want 0001", ib.req_ready);
        end
        ib.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_a(0, 1'b1, 1'b0, 10'd0, 16'h0);
        #1;
        checks++;
        if (ia.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_grant got %b want 0001", ia.req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ia.req_valid = '0;
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b0000 || ia.rsp_rdata !== '0) begin
            errors++;
            $display("FAIL midrst_drop got %b/%h want 0000/0", ia.rsp_valid, ia.rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_no_pulse got %b want 0000", ia.rsp_valid);
        end
        @(negedge clk);
        set_a(3, 1'b1, 1'b0, 10'd2, 16'h0);
        @(posedge clk);
        #1;
        checks++;
        if (ia.rsp_valid !== 4'b1000 || ia.rsp_rdata[3*DW +: DW] !== 16'hA002) begin
            errors++;
            $display("FAIL midrst_persist got %b/%h want 1000/a002", ia.rsp_valid, ia.rsp_rdata[3*DW +: DW]);
        end
        @(negedge clk);
        ia.req_valid = '0;
    endtask

    initial begin
        ia.req_valid = '0;
        ia.req_we = '0;
        ia.req_addr = '0;
        ia.req_wdata = '0;
        ib.req_valid = '0;
        ib.req_we = '0;
        ib.req_addr = '0;
        ib.req_wdata = '0;
        test_reset();
        test_conflict();
        test_wrap();
        test_parallel();
        test_back_to_back();
        test_interleave0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
